// File: rtl/max7219_pkg.sv
// Shared constants, FSM encoding and frame-mapping helpers for the MAX7219 display path.
package max7219_pkg;

    localparam int DIGITS_PER_CASCADE = 8;
    localparam int BYTES_PER_CASCADE  = 4;
    localparam int NIBBLE_W           = 4;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CONVERT = 1'b1
    } bcd_state_e;

    // Frame byte holding decimal digit k (k = 0 is the least significant digit).
    // Within a cascade the highest digit pair sits in the lowest byte.
    function automatic int frame_byte_idx(input int k);
        return BYTES_PER_CASCADE * (k / DIGITS_PER_CASCADE)
             + (BYTES_PER_CASCADE - 1)
             - (k % DIGITS_PER_CASCADE) / 2;
    endfunction

    // Bit offset of digit k inside its frame byte: even digits low nibble, odd digits high.
    function automatic int frame_nibble_lsb(input int k);
        return NIBBLE_W * ((k % DIGITS_PER_CASCADE) % 2);
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
    import max7219_pkg::*;
(
    input  logic [NIBBLE_W-1:0] digit_i,
    output logic [NIBBLE_W-1:0] digit_o
);

    // Conditional +3 ahead of the shift.
    always_comb begin
        digit_o = (digit_i >= NIBBLE_W'(5)) ? digit_i + NIBBLE_W'(3) : digit_i;
    end

endmodule

// File: rtl/max7219_bcd_frame.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle, MSB first)
// that delivers its digits as a packed byte frame for the MAX7219 display driver.
module max7219_bcd_frame
    import max7219_pkg::*;
#(
    parameter int NUM_CASCADES = 1,
    parameter int BIN_W        = 27
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BIN_W-1:0] bin,
    output logic [7:0]       frame [BYTES_PER_CASCADE*NUM_CASCADES],
    output logic             frame_valid,
    output logic             overflow
);

    localparam int NUM_DIGITS = DIGITS_PER_CASCADE * NUM_CASCADES;
    localparam int NUM_BYTES  = BYTES_PER_CASCADE * NUM_CASCADES;
    localparam int BCD_W      = NIBBLE_W * NUM_DIGITS;
    localparam int CNT_W      = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int LAST_ITER  = BIN_W - 1;

    bcd_state_e         state_q, state_d;
    logic [BIN_W-1:0]   bin_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_work_q;
    logic [8*NUM_BYTES-1:0] frame_q;
    logic               overflow_q;
    logic               frame_valid_q;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_shift;
    logic [8*NUM_BYTES-1:0] frame_map;
    logic               handshake;
    logic               last_iter;

    assign handshake = in_valid && (state_q == ST_IDLE);
    assign last_iter = (state_q == ST_CONVERT) && (cnt_q == CNT_W'(LAST_ITER));

    // The digit that would leave the register is the adjusted top digit's MSB;
    // the new binary bit enters at the bottom.
    assign bcd_shift = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            localparam int BYTE_IDX = frame_byte_idx(gi);
            localparam int NIB_LSB  = frame_nibble_lsb(gi);

            bcd_digit_adjust u_adjust (
                .digit_i (bcd_q  [NIBBLE_W*gi +: NIBBLE_W]),
                .digit_o (bcd_adj[NIBBLE_W*gi +: NIBBLE_W])
            );

            assign frame_map[8*BYTE_IDX + NIB_LSB +: NIBBLE_W] = bcd_shift[NIBBLE_W*gi +: NIBBLE_W];
        end

        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_frame_out
            assign frame[gi] = frame_q[8*gi +: 8];
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // FSM next state: accept in IDLE, leave CONVERT after the final bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (handshake) state_d = ST_CONVERT;
            ST_CONVERT: if (last_iter) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: ready only while idle.
    always_comb begin
        in_ready = (state_q == ST_IDLE);
    end

    // Working registers: capture on handshake, then one double-dabble step per cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_work_q <= 1'b0;
        end else if (handshake) begin
            bin_q      <= bin;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_work_q <= 1'b0;
        end else if (state_q == ST_CONVERT) begin
            bin_q      <= bin_q << 1;
            bcd_q      <= bcd_shift;
            cnt_q      <= cnt_q + CNT_W'(1);
            ovf_work_q <= ovf_work_q | bcd_adj[BCD_W-1];
        end
    end

    // Output registers: load the final step straight into the frame and pulse valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_q       <= '0;
            overflow_q    <= 1'b0;
            frame_valid_q <= 1'b0;
        end else begin
            frame_valid_q <= last_iter;
            if (last_iter) begin
                frame_q    <= frame_map;
                overflow_q <= ovf_work_q | bcd_adj[BCD_W-1];
            end
        end
    end

    assign frame_valid = frame_valid_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_max7219_bcd_frame.sv
// Self-checking bench for max7219_bcd_frame: one- and two-cascade instances,
// directed corner cases plus random values against a decimal reference model.
module tb_max7219_bcd_frame;

    logic        clk;
    logic        reset_n;

    logic        in_valid1, in_ready1, fv1, ovf1;
    logic [26:0] bin1;
    logic [7:0]  frame1 [4];

    logic        in_valid2, in_ready2, fv2, ovf2;
    logic [53:0] bin2;
    logic [7:0]  frame2 [8];

    int compared   = 0;
    int mismatched = 0;
    int pulses1    = 0;
    int pulses2    = 0;

    max7219_bcd_frame #(.NUM_CASCADES(1), .BIN_W(27)) dut1 (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid1),
        .in_ready    (in_ready1),
        .bin         (bin1),
        .frame       (frame1),
        .frame_valid (fv1),
        .overflow    (ovf1)
    );

    max7219_bcd_frame #(.NUM_CASCADES(2), .BIN_W(54)) dut2 (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid2),
        .in_ready    (in_ready2),
        .bin         (bin2),
        .frame       (frame2),
        .frame_valid (fv2),
        .overflow    (ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles in which each frame_valid is high.
    always @(posedge clk) begin
        if (fv1 === 1'b1) pulses1 <= pulses1 + 1;
        if (fv2 === 1'b1) pulses2 <= pulses2 + 1;
    end

    // ---------------- reference model (decimal arithmetic) ----------------
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    function automatic logic [7:0] model_byte(input logic [63:0] v, input int nc, input int b);
        logic [63:0] m;
        logic [63:0] d;
        logic [7:0]  res;
        m   = v % pow10(8 * nc);
        res = 8'h00;
        for (int k = 0; k < 8 * nc; k++) begin
            d = m % 64'd10;
            m = m / 64'd10;
            if (4 * (k / 8) + 3 - (k % 8) / 2 == b) begin
                if ((k % 8) % 2 == 0) res[3:0] = d[3:0];
                else                  res[7:4] = d[3:0];
            end
        end
        return res;
    endfunction

    function automatic logic model_ovf(input logic [63:0] v, input int nc);
        return v > pow10(8 * nc) - 64'd1;
    endfunction

    // ---------------- DUT accessors ----------------
    function automatic logic [7:0] get_byte(input int inst, input int b);
        if (inst == 1) return (b < 4) ? frame1[b] : 8'hxx;
        return frame2[b];
    endfunction

    function automatic logic get_fv(input int inst);
        return (inst == 1) ? fv1 : fv2;
    endfunction

    function automatic logic get_ready(input int inst);
        return (inst == 1) ? in_ready1 : in_ready2;
    endfunction

    function automatic logic get_ovf(input int inst);
        return (inst == 1) ? ovf1 : ovf2;
    endfunction

    function automatic int get_pulses(input int inst);
        return (inst == 1) ? pulses1 : pulses2;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int inst, input logic valid, input logic [63:0] v);
        if (inst == 1) begin
            in_valid1 = valid;
            bin1      = v[26:0];
        end else begin
            in_valid2 = valid;
            bin2      = v[53:0];
        end
    endtask

    // Handshake v, optionally keep in_valid high with next_bin, wait for the
    // result and compare latency, hold behaviour, frame and overflow.
    task automatic convert(input int inst, input logic [63:0] v, input bit keep_valid,
                           input logic [63:0] next_bin, input string tag);
        int         lat;
        int         p0;
        int         nb;
        int         nc;
        int         bw;
        logic [7:0] prev [8];
        nc = (inst == 1) ? 1 : 2;
        nb = 4 * nc;
        bw = 27 * nc;
        for (int b = 0; b < nb; b++) prev[b] = get_byte(inst, b);
        chk($sformatf("%s.ready_before", tag), get_ready(inst), 1'b1);
        drive(inst, 1'b1, v);
        @(posedge clk);
        #1;
        p0 = get_pulses(inst);
        if (keep_valid) drive(inst, 1'b1, next_bin);
        else            drive(inst, 1'b0, 64'd0);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 13) begin
                chk($sformatf("%s.ready_busy", tag), get_ready(inst), 1'b0);
                for (int b = 0; b < nb; b++)
                    chk($sformatf("%s.hold[%0d]", tag, b), get_byte(inst, b), prev[b]);
            end
        end while (get_fv(inst) !== 1'b1 && lat < 200);
        chk($sformatf("%s.latency", tag), lat, bw);
        chk($sformatf("%s.early_pulses", tag), get_pulses(inst) - p0, 0);
        chk($sformatf("%s.ready_at_valid", tag), get_ready(inst), 1'b1);
        for (int b = 0; b < nb; b++)
            chk($sformatf("%s.frame[%0d]", tag, b), get_byte(inst, b), model_byte(v, nc, b));
        chk($sformatf("%s.overflow", tag), get_ovf(inst), model_ovf(v, nc));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] rv;
        int          p_before;

        in_valid1 = 1'b0; bin1 = '0;
        in_valid2 = 1'b0; bin2 = '0;
        reset_n   = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("reset.ready", in_ready1, 1'b1);
        chk("reset.fv", fv1, 1'b0);
        chk("reset.ovf", ovf1, 1'b0);
        for (int b = 0; b < 4; b++) chk($sformatf("reset.frame[%0d]", b), frame1[b], 8'h00);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Handshake on the first edge after reset release.
        convert(1, 64'd12345678, 1'b0, 64'd0, "dec12345678");
        idle(1);
        chk("dec12345678.pulse_width", fv1, 1'b0);

        convert(1, 64'd100000000, 1'b0, 64'd0, "ovf1e8");
        idle(2);

        // Back-to-back: second handshake in the frame_valid cycle.
        convert(1, 64'd0, 1'b0, 64'd0, "b2b_zero");
        convert(1, 64'd99999999, 1'b0, 64'd0, "b2b_nines");
        idle(1);
        chk("b2b_nines.pulse_width", fv1, 1'b0);

        // in_valid held with bin changed during conversion of 42.
        convert(1, 64'd42, 1'b1, 64'd5, "hold42");
        convert(1, 64'd5, 1'b0, 64'd0, "after42");
        idle(1);
        chk("after42.pulse_width", fv1, 1'b0);

        // Reset in the middle of a conversion.
        convert(1, 64'd123456789, 1'b0, 64'd0, "pre_reset");
        idle(2);
        drive(1, 1'b1, 64'd777);
        @(posedge clk);
        #1;
        drive(1, 1'b0, 64'd0);
        p_before = pulses1;
        idle(10);
        chk("midreset.busy", in_ready1, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("midreset.ready", in_ready1, 1'b1);
        chk("midreset.ovf", ovf1, 1'b0);
        chk("midreset.fv", fv1, 1'b0);
        for (int b = 0; b < 4; b++) chk($sformatf("midreset.frame[%0d]", b), frame1[b], 8'h00);
        @(posedge clk);
        #1 reset_n = 1'b1;
        idle(30);
        chk("midreset.no_pulse", pulses1 - p_before, 0);
        for (int b = 0; b < 4; b++) chk($sformatf("midreset.kept[%0d]", b), frame1[b], 8'h00);

        // Random single-cascade values, some above 99999999.
        for (int i = 0; i < 8; i++) begin
            rv = 64'($urandom_range(0, 134217727));
            convert(1, rv, 1'b0, 64'd0, $sformatf("rand1_%0d", i));
            idle(i % 2);
        end

        // Two cascades.
        convert(2, 64'd1234567890123456, 1'b0, 64'd0, "c2_dec");
        idle(1);
        convert(2, 64'd9999999999999999, 1'b0, 64'd0, "c2_max");
        convert(2, 64'd10000000000000000, 1'b0, 64'd0, "c2_ovf");
        idle(1);
        for (int i = 0; i < 4; i++) begin
            rv = {32'($urandom), 32'($urandom)} & ((64'd1 << 54) - 64'd1);
            convert(2, rv, 1'b0, 64'd0, $sformatf("rand2_%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
